// File: rtl/d_branch_seq_pkg.sv
// Shared definitions for the decode-stage branch sequencer.
//   btype_e  : D-stage branch type encoding (7 is reserved and acts as "none")
//   state_e  : sequencer FSM states
//   TNEW_W   : width of the E/M "cycles until result ready" fields
package d_branch_seq_pkg;

  localparam int unsigned TNEW_W = 2;

  typedef enum logic [2:0] {
    BT_NONE = 3'd0,
    BT_BEQ  = 3'd1,
    BT_BNE  = 3'd2,
    BT_BGTZ = 3'd3,
    BT_BLTZ = 3'd4,
    BT_BGEZ = 3'd5,
    BT_BLEZ = 3'd6,
    BT_RSVD = 3'd7
  } btype_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic is_branch(input logic [2:0] bt);
    return (bt != BT_NONE) && (bt != BT_RSVD);
  endfunction

  function automatic logic uses_rt(input logic [2:0] bt);
    return (bt == BT_BEQ) || (bt == BT_BNE);
  endfunction

endpackage

// File: rtl/d_branch_seq_cmp.sv
// Purely combinational branch condition evaluator.
//   btype : branch type (d_branch_seq_pkg::btype_e encoding)
//   rs    : first source operand (forwarded)
//   rt    : second source operand (forwarded), used by beq/bne only
//   cond  : 1 when the branch condition holds; 0 for non-branch types
module branch_cmp
  import d_branch_seq_pkg::*;
(
  input  logic [2:0]  btype,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        cond
);

  logic eq;
  logic neg;
  logic zero;

  assign eq   = (rs == rt);
  assign neg  = rs[31];
  assign zero = (rs == '0);

  always_comb begin
    cond = 1'b0;
    case (btype_e'(btype))
      BT_BEQ:  cond = eq;
      BT_BNE:  cond = !eq;
      BT_BGTZ: cond = !neg && !zero;
      BT_BLTZ: cond = neg;
      BT_BGEZ: cond = !neg;
      BT_BLEZ: cond = neg || zero;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_branch_seq.sv
// Decode-stage branch sequencer. Holds a conditional branch in D until its
// source registers are free of E/M-stage hazards, resolves it through
// branch_cmp and drives the next-PC redirect. Keeps resolution statistics.
//   clk, reset (active-low, synchronous)
//   d_btype, d_rs_addr, d_rt_addr, d_rs_data, d_rt_data, d_pc, d_imm16 : D-stage branch
//   e_wa/e_tnew, m_wa/m_tnew : pending writers in E and M
//   ext_stall      : stall from other hazard sources (blocks resolution only)
//   stall          : operand-hazard stall request (combinational)
//   redirect_valid : branch resolved taken this cycle (combinational)
//   redirect_pc    : branch target, always driven
//   br_total, br_taken : resolved / taken branch counters (wrapping)
//   max_wait       : longest hazard wait observed, in cycles
//   state_wait     : FSM is in WAIT
module d_branch_seq
  import d_branch_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        d_btype,
  input  logic [4:0]        d_rs_addr,
  input  logic [4:0]        d_rt_addr,
  input  logic [31:0]       d_rs_data,
  input  logic [31:0]       d_rt_data,
  input  logic [31:0]       d_pc,
  input  logic [15:0]       d_imm16,
  input  logic [4:0]        e_wa,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic [4:0]        m_wa,
  input  logic [TNEW_W-1:0] m_tnew,
  input  logic              ext_stall,
  output logic              stall,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  br_total,
  output logic [CNT_W-1:0]  br_taken,
  output logic [7:0]        max_wait,
  output logic              state_wait
);

  state_e     state;
  logic [7:0] wait_cnt;

  logic br;
  logic hz;
  logic resolve;
  logic cond;
  logic taken;
  logic rs_hz;
  logic rt_hz;

  function automatic logic src_hazard(
    input logic [4:0]        s,
    input logic [4:0]        ewa,
    input logic [TNEW_W-1:0] etn,
    input logic [4:0]        mwa,
    input logic [TNEW_W-1:0] mtn
  );
    return (s != '0) && (((s == ewa) && (etn != '0)) || ((s == mwa) && (mtn != '0)));
  endfunction

  assign br      = is_branch(d_btype);
  assign rs_hz   = src_hazard(d_rs_addr, e_wa, e_tnew, m_wa, m_tnew);
  assign rt_hz   = src_hazard(d_rt_addr, e_wa, e_tnew, m_wa, m_tnew);
  assign hz      = br && (rs_hz || (uses_rt(d_btype) && rt_hz));
  assign resolve = br && !hz && !ext_stall;
  assign taken   = resolve && cond;

  branch_cmp u_cmp (
    .btype (d_btype),
    .rs    (d_rs_data),
    .rt    (d_rt_data),
    .cond  (cond)
  );

  assign stall          = hz;
  assign redirect_valid = taken;
  assign redirect_pc    = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign state_wait     = (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      max_wait <= '0;
      br_total <= '0;
      br_taken <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hz) begin
            state    <= ST_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (hz) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 8'd1;
          end else begin
            // Leaving WAIT with the branch still present records the wait even
            // if ext_stall defers the actual resolution to IDLE.
            state    <= ST_IDLE;
            wait_cnt <= '0;
            if (br && (wait_cnt > max_wait)) max_wait <= wait_cnt;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase

      if (resolve) begin
        br_total <= br_total + CNT_W'(1);
        if (taken) br_taken <= br_taken + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_d_branch_seq.sv
module tb_d_branch_seq;
  import d_branch_seq_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned CMASK = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        d_btype;
  logic [4:0]        d_rs_addr, d_rt_addr;
  logic [31:0]       d_rs_data, d_rt_data, d_pc;
  logic [15:0]       d_imm16;
  logic [4:0]        e_wa, m_wa;
  logic [TNEW_W-1:0] e_tnew, m_tnew;
  logic              ext_stall;
  logic              stall, redirect_valid, state_wait;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  br_total, br_taken;
  logic [7:0]        max_wait;

  d_branch_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .d_btype(d_btype),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_rs_data(d_rs_data), .d_rt_data(d_rt_data),
    .d_pc(d_pc), .d_imm16(d_imm16),
    .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .ext_stall(ext_stall), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_total(br_total), .br_taken(br_taken),
    .max_wait(max_wait), .state_wait(state_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    int unsigned total;
    int unsigned taken;
    int unsigned maxw;
    logic        sw;
  } exp_t;

  exp_t scb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: counts and the length of the current hazard run.
  int unsigned m_total = 0, m_taken = 0, m_maxw = 0, m_run = 0;

  function automatic bit reg_busy(input int unsigned s);
    return s != 0 && ((s == e_wa && e_tnew > 0) || (s == m_wa && m_tnew > 0));
  endfunction

  function automatic bit cond_true(input int unsigned bt, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (bt)
      1: return a == b;
      2: return a != b;
      3: return sa > 0;
      4: return sa < 0;
      5: return sa >= 0;
      6: return sa <= 0;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  // One cycle: predict this cycle's outputs, queue them, advance the model.
  task automatic step();
    exp_t e;
    bit   is_br, hz, res, tk;
    int   off;
    is_br = (d_btype >= 1 && d_btype <= 6);
    hz    = is_br && (reg_busy(d_rs_addr) ||
             ((d_btype == 1 || d_btype == 2) && reg_busy(d_rt_addr)));
    res   = is_br && !hz && !ext_stall;
    tk    = res && cond_true(d_btype, d_rs_data, d_rt_data);
    off   = $signed(d_imm16);
    e.stall = hz;
    e.rv    = tk;
    e.rpc   = d_pc + 32'd4 + 32'(off * 4);
    e.total = m_total;
    e.taken = m_taken;
    e.maxw  = m_maxw;
    e.sw    = (m_run > 0);
    scb.push_back(e);
    if (!reset) begin
      m_total = 0; m_taken = 0; m_maxw = 0; m_run = 0;
    end else begin
      if (res) begin
        m_total = (m_total + 1) & CMASK;
        if (tk) m_taken = (m_taken + 1) & CMASK;
      end
      if (hz) begin
        if (m_run < 255) m_run++;
      end else begin
        if (m_run > 0 && is_br && m_run > m_maxw) m_maxw = m_run;
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        check("stall",          stall,          e.stall);
        check("redirect_valid", redirect_valid, e.rv);
        check("redirect_pc",    redirect_pc,    e.rpc);
        check("br_total",       br_total,       e.total);
        check("br_taken",       br_taken,       e.taken);
        check("max_wait",       max_wait,       e.maxw);
        check("state_wait",     state_wait,     e.sw);
      end
    end
  end

  task automatic set_br(input int unsigned bt, input int unsigned rsa, input int unsigned rta,
                        input logic [31:0] rsd, input logic [31:0] rtd);
    d_btype = 3'(bt); d_rs_addr = 5'(rsa); d_rt_addr = 5'(rta);
    d_rs_data = rsd; d_rt_data = rtd;
  endtask

  task automatic clear_hz();
    e_wa = '0; e_tnew = '0; m_wa = '0; m_tnew = '0; ext_stall = 1'b0;
  endtask

  initial begin
    int wait_cycles;
    reset = 1'b0;
    set_br(0, 0, 0, '0, '0);
    d_pc = 32'h3000; d_imm16 = 16'h0004;
    clear_hz();
    @(posedge clk); #1;
    step();                       // reset state check
    reset = 1'b1;

    // Hazard-free beq, taken: target 0x3014.
    set_br(1, 1, 2, 32'd5, 32'd5);
    step();
    // bltz on 0x8000_0000: taken.
    set_br(4, 1, 0, 32'h8000_0000, '0); d_imm16 = 16'hFFFC;
    step();
    // bgtz on 0: not taken.
    set_br(3, 1, 0, 32'd0, '0);
    step();
    set_br(0, 0, 0, '0, '0);
    step();

    // bne on r3 with an E-stage writer two cycles out.
    set_br(2, 3, 4, 32'd1, 32'd2);
    e_wa = 5'd3; e_tnew = 2'd2;
    step(); step();
    e_tnew = 2'd0;
    step();
    set_br(0, 0, 0, '0, '0); clear_hz();
    step();

    // r0 never hazards.
    set_br(1, 0, 0, '0, '0); e_wa = 5'd0; e_tnew = 2'd2;
    step();
    clear_hz();

    // bgez on r3 with M-stage writer, ext_stall held for three cycles.
    set_br(5, 3, 0, 32'd7, '0);
    m_wa = 5'd3; m_tnew = 2'd1; ext_stall = 1'b1;
    step();
    m_tnew = 2'd0;
    step(); step();
    ext_stall = 1'b0;
    step();
    clear_hz();

    // Reset asserted while in WAIT.
    set_br(2, 3, 0, 32'd1, 32'd2); e_wa = 5'd3; e_tnew = 2'd1;
    step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1; clear_hz();
    step();

    // Randomized mix.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 4))
        0: v = '0;
        1: v = 32'd1;
        2: v = '1;
        3: v = 32'h8000_0000;
        default: v = $urandom;
      endcase
      set_br($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
             v, ($urandom_range(0, 1) == 1) ? v : 32'($urandom));
      d_pc = $urandom; d_imm16 = 16'($urandom);
      e_wa = 5'($urandom_range(0, 3)); e_tnew = 2'($urandom_range(0, 3));
      m_wa = 5'($urandom_range(0, 3)); m_tnew = 2'($urandom_range(0, 3));
      ext_stall = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 60) != 0);
      step();
    end

    // Counter wrap: 2^CNT_W + 1 taken resolutions from a clean reset.
    reset = 1'b0; clear_hz(); set_br(0, 0, 0, '0, '0);
    step();
    reset = 1'b1;
    set_br(1, 1, 1, 32'd9, 32'd9);
    for (int i = 0; i < (1 << CNT_W) + 1; i++) step();
    set_br(0, 0, 0, '0, '0);
    step();

    wait_cycles = 0;
    while (scb.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    check("scoreboard_drained", scb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
